// File: rtl/cisr_pkg.sv
// Shared types and default widths for the CISR row-length tracking logic.
package cisr_pkg;

    typedef enum logic {
        EMPTY  = 1'b0,
        ACTIVE = 1'b1
    } lane_state_t;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_LEN_W   = 5;
    localparam int DEF_ROWID_W = 8;

endpackage

// File: rtl/cisr_lane_counter.sv
// One CISR lane: holds the remaining nonzero count and row id of the row being
// consumed, and pulses row_done when that row (or a zero-length row) finishes.
//
//   state  | meaning
//   EMPTY  | no row held; lane can accept a length
//   ACTIVE | row in progress; count = nonzeros still to consume (never 0)
module cisr_lane_counter
    import cisr_pkg::*;
#(
    parameter int LEN_W   = DEF_LEN_W,
    parameter int ROWID_W = DEF_ROWID_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               load,
    input  logic [LEN_W-1:0]   load_len,
    input  logic [ROWID_W-1:0] load_id,
    input  logic               step,
    output logic               need,
    output logic               step_err,
    output logic [LEN_W-1:0]   count,
    output logic [ROWID_W-1:0] row_id,
    output logic               busy,
    output logic               row_done,
    output logic [ROWID_W-1:0] done_id
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    lane_state_t        state_q, state_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [ROWID_W-1:0] row_id_q, row_id_d;
    logic               row_done_q, row_done_d;
    logic [ROWID_W-1:0] done_id_q, done_id_d;
    logic               zero_pend_q, zero_pend_d;
    logic               finishing;

    assign finishing = (state_q == ACTIVE) && step && (count_q == LEN_ONE);
    // A zero-length row loaded onto a finishing lane reports its done one cycle
    // later; the lane refuses new lengths until that pulse has gone out.
    assign need      = ((state_q == EMPTY) && !zero_pend_q) || finishing;
    assign step_err  = step && (state_q != ACTIVE);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        row_id_d    = row_id_q;
        row_done_d  = 1'b0;
        done_id_d   = done_id_q;
        zero_pend_d = 1'b0;
        if (flush) begin
            state_d   = EMPTY;
            count_d   = '0;
            row_id_d  = '0;
            done_id_d = '0;
        end else begin
            if ((state_q == ACTIVE) && step) begin
                count_d = count_q - LEN_ONE;
                if (count_q == LEN_ONE) begin
                    state_d    = EMPTY;
                    row_done_d = 1'b1;
                    done_id_d  = row_id_q;
                end
            end
            if (zero_pend_q) begin
                row_done_d = 1'b1;
                done_id_d  = row_id_q;
            end
            if (load) begin
                row_id_d = load_id;
                if (load_len != '0) begin
                    state_d = ACTIVE;
                    count_d = load_len;
                end else if (finishing) begin
                    zero_pend_d = 1'b1;
                end else begin
                    row_done_d = 1'b1;
                    done_id_d  = load_id;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            count_q     <= '0;
            row_id_q    <= '0;
            row_done_q  <= 1'b0;
            done_id_q   <= '0;
            zero_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            row_id_q    <= row_id_d;
            row_done_q  <= row_done_d;
            done_id_q   <= done_id_d;
            zero_pend_q <= zero_pend_d;
        end
    end

    assign count    = count_q;
    assign row_id   = row_id_q;
    assign busy     = (state_q == ACTIVE);
    assign row_done = row_done_q;
    assign done_id  = done_id_q;

endmodule

// File: rtl/cisr_multi_row_counter.sv
// Multi-lane CISR row-length tracker: hands each incoming row length to the
// lowest-index lane that needs one and numbers rows with a wrapping id.
module cisr_multi_row_counter
    import cisr_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int ROWID_W = DEF_ROWID_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      len_valid,
    input  logic [LEN_W-1:0]          len_data,
    output logic                      len_ready,
    input  logic [NUM_CH-1:0]         step,
    output logic [NUM_CH*LEN_W-1:0]   count,
    output logic [NUM_CH*ROWID_W-1:0] row_id,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         row_done,
    output logic [NUM_CH*ROWID_W-1:0] done_id,
    output logic                      err_step
);

    localparam logic [ROWID_W-1:0] ID_ONE = ROWID_W'(1);

    logic [NUM_CH-1:0]  need;
    logic [NUM_CH-1:0]  step_err;
    logic [NUM_CH-1:0]  load_oh;
    logic               found;
    logic               xfer;
    logic [ROWID_W-1:0] next_id_q, next_id_d;
    logic               err_step_q, err_step_d;

    // flush wins over loads, so nothing is accepted while it is asserted
    assign len_ready = (|need) && !flush;
    assign xfer      = len_valid && len_ready;

    always_comb begin
        load_oh = '0;
        found   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (need[c] && !found) begin
                load_oh[c] = xfer;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        next_id_d  = next_id_q;
        err_step_d = err_step_q;
        if (flush) begin
            next_id_d = '0;
        end else begin
            if (xfer) begin
                next_id_d = next_id_q + ID_ONE;
            end
            if (|step_err) begin
                err_step_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_id_q  <= '0;
            err_step_q <= 1'b0;
        end else begin
            next_id_q  <= next_id_d;
            err_step_q <= err_step_d;
        end
    end

    assign err_step = err_step_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        cisr_lane_counter #(
            .LEN_W   (LEN_W),
            .ROWID_W (ROWID_W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .load     (load_oh[c]),
            .load_len (len_data),
            .load_id  (next_id_q),
            .step     (step[c]),
            .need     (need[c]),
            .step_err (step_err[c]),
            .count    (count[c*LEN_W +: LEN_W]),
            .row_id   (row_id[c*ROWID_W +: ROWID_W]),
            .busy     (busy[c]),
            .row_done (row_done[c]),
            .done_id  (done_id[c*ROWID_W +: ROWID_W])
        );
    end

endmodule

// File: tb/tb_cisr_multi_row_counter.sv
// Bench for cisr_multi_row_counter: directed scenarios plus a randomized stream
// compared against a row-level reference model.
module tb_cisr_multi_row_counter;

    localparam int NUM_CH  = 4;
    localparam int LEN_W   = 5;
    localparam int ROWID_W = 8;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      flush;
    logic                      len_valid;
    logic [LEN_W-1:0]          len_data;
    logic                      len_ready;
    logic [NUM_CH-1:0]         step;
    logic [NUM_CH*LEN_W-1:0]   count;
    logic [NUM_CH*ROWID_W-1:0] row_id;
    logic [NUM_CH-1:0]         busy;
    logic [NUM_CH-1:0]         row_done;
    logic [NUM_CH*ROWID_W-1:0] done_id;
    logic                      err_step;

    int checks   = 0;
    int failures = 0;

    int m_cnt[NUM_CH];
    int m_id[NUM_CH];
    int m_done_id[NUM_CH];
    bit m_busy[NUM_CH];
    bit m_done[NUM_CH];
    int m_next;
    bit m_err;

    cisr_multi_row_counter #(
        .NUM_CH  (NUM_CH),
        .LEN_W   (LEN_W),
        .ROWID_W (ROWID_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .len_valid (len_valid),
        .len_data  (len_data),
        .len_ready (len_ready),
        .step      (step),
        .count     (count),
        .row_id    (row_id),
        .busy      (busy),
        .row_done  (row_done),
        .done_id   (done_id),
        .err_step  (err_step)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (row level) ----------------
    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = 0; m_id[c] = 0; m_done_id[c] = 0; m_busy[c] = 0; m_done[c] = 0;
        end
        m_next = 0;
        m_err  = 0;
    endfunction

    function automatic bit m_need(int c);
        return !m_busy[c] || (m_cnt[c] == 1 && step[c]);
    endfunction

    function automatic int m_target();
        for (int c = 0; c < NUM_CH; c++) if (m_need(c)) return c;
        return -1;
    endfunction

    function automatic bit m_ready();
        return !flush && (m_target() >= 0);
    endfunction

    function automatic void model_edge();
        int tgt;
        bit xfer;
        tgt  = m_target();
        xfer = len_valid && m_ready();
        if (flush) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_cnt[c] = 0; m_id[c] = 0; m_done_id[c] = 0; m_busy[c] = 0; m_done[c] = 0;
            end
            m_next = 0;
            return;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            m_done[c] = 0;
            if (m_busy[c] && step[c]) begin
                m_cnt[c] = m_cnt[c] - 1;
                if (m_cnt[c] == 0) begin
                    m_busy[c] = 0; m_done[c] = 1; m_done_id[c] = m_id[c];
                end
            end else if (step[c]) begin
                m_err = 1;
            end
        end
        if (xfer) begin
            m_id[tgt] = m_next;
            if (len_data != 0) begin
                m_busy[tgt] = 1; m_cnt[tgt] = int'(len_data);
            end else begin
                m_done[tgt] = 1; m_done_id[tgt] = m_next;
            end
            m_next = (m_next + 1) % (1 << ROWID_W);
        end
    endfunction

    function automatic logic [NUM_CH*LEN_W-1:0] exp_count();
        logic [NUM_CH*LEN_W-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c*LEN_W +: LEN_W] = LEN_W'(m_cnt[c]);
        return v;
    endfunction

    function automatic logic [NUM_CH*ROWID_W-1:0] exp_row_id();
        logic [NUM_CH*ROWID_W-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c*ROWID_W +: ROWID_W] = ROWID_W'(m_id[c]);
        return v;
    endfunction

    function automatic logic [NUM_CH*ROWID_W-1:0] exp_done_id();
        logic [NUM_CH*ROWID_W-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c*ROWID_W +: ROWID_W] = ROWID_W'(m_done_id[c]);
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_busy();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_busy[c];
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_done();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_done[c];
        return v;
    endfunction

    // ---------------- stimulus plumbing ----------------
    task automatic drive(input bit v, input int l, input logic [NUM_CH-1:0] s, input bit f);
        len_valid = v;
        len_data  = LEN_W'(l);
        step      = s;
        flush     = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, '0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({count, row_id, busy, row_done, done_id, err_step} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got count=%h row_id=%h busy=%b done=%b done_id=%h err=%b, expected all zero",
                     count, row_id, busy, row_done, done_id, err_step);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (len_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_len_ready: got %b expected 1", len_ready);
        end
    endtask

    task automatic test_single_row();
        logic [LEN_W-1:0] exp_c;
        drive(1, 4, '0, 0);
        tick();
        checks++;
        if (count[LEN_W-1:0] !== 5'd4 || busy !== 4'b0001 || row_id[ROWID_W-1:0] !== 8'd0) begin
            failures++;
            $display("FAIL single_load: got count0=%0d busy=%b id0=%0d expected 4 0001 0",
                     count[LEN_W-1:0], busy, row_id[ROWID_W-1:0]);
        end
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 4'b0001, 0);
            tick();
            exp_c = LEN_W'(4 - k);
            checks++;
            if (count[LEN_W-1:0] !== exp_c || row_done[0] !== (k == 4)) begin
                failures++;
                $display("FAIL single_step%0d: got count0=%0d done0=%b expected %0d %b",
                         k, count[LEN_W-1:0], row_done[0], exp_c, (k == 4));
            end
        end
        checks++;
        if (done_id[ROWID_W-1:0] !== 8'd0 || busy !== 4'b0000) begin
            failures++;
            $display("FAIL single_done: got done_id0=%0d busy=%b expected 0 0000", done_id[ROWID_W-1:0], busy);
        end
        drive(0, 0, '0, 0);
        tick();
        checks++;
        if (row_done !== 4'b0000) begin
            failures++;
            $display("FAIL single_pulse: got row_done=%b expected 0000", row_done);
        end
    endtask

    task automatic test_back_to_back();
        int lens[4] = '{3, 2, 5, 1};
        drive(0, 0, '0, 1);
        tick();
        foreach (lens[i]) begin
            drive(1, lens[i], '0, 0);
            tick();
        end
        checks++;
        if (busy !== 4'b1111 || row_id !== 32'h03020100) begin
            failures++;
            $display("FAIL fill_ids: got busy=%b row_id=%h expected 1111 03020100", busy, row_id);
        end
        checks++;
        if (count !== {5'd1, 5'd5, 5'd2, 5'd3}) begin
            failures++;
            $display("FAIL fill_counts: got %h expected %h", count, {5'd1, 5'd5, 5'd2, 5'd3});
        end
        drive(1, 7, '0, 0);
        checks++;
        if (len_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_ready: got %b expected 0", len_ready);
        end
        tick();
        checks++;
        if (count !== {5'd1, 5'd5, 5'd2, 5'd3} || busy !== 4'b1111) begin
            failures++;
            $display("FAIL fill_hold: got count=%h busy=%b, expected unchanged", count, busy);
        end
    endtask

    task automatic test_zero_len();
        drive(0, 0, 4'b1000, 0);
        tick();
        checks++;
        if (row_done !== 4'b1000 || done_id[31:24] !== 8'd3 || busy !== 4'b0111) begin
            failures++;
            $display("FAIL zero_prep: got done=%b id3=%0d busy=%b expected 1000 3 0111",
                     row_done, done_id[31:24], busy);
        end
        drive(1, 0, '0, 0);
        checks++;
        if (len_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_ready: got %b expected 1", len_ready);
        end
        tick();
        checks++;
        if (busy !== 4'b0111 || row_done !== 4'b1000 || done_id[31:24] !== 8'd4 || count[19:15] !== 5'd0) begin
            failures++;
            $display("FAIL zero_done: got busy=%b done=%b id3=%0d cnt3=%0d expected 0111 1000 4 0",
                     busy, row_done, done_id[31:24], count[19:15]);
        end
    endtask

    task automatic test_reload();
        drive(0, 0, 4'b0010, 0);
        tick();
        checks++;
        if (count[9:5] !== 5'd1 || row_done !== 4'b0000) begin
            failures++;
            $display("FAIL reload_prep: got cnt1=%0d done=%b expected 1 0000", count[9:5], row_done);
        end
        drive(1, 6, 4'b0010, 0);
        tick();
        checks++;
        if (row_done !== 4'b0010 || done_id[15:8] !== 8'd1) begin
            failures++;
            $display("FAIL reload_done: got done=%b id1=%0d expected 0010 1", row_done, done_id[15:8]);
        end
        checks++;
        if (count[9:5] !== 5'd6 || row_id[15:8] !== 8'd5 || busy !== 4'b0111) begin
            failures++;
            $display("FAIL reload_new: got cnt1=%0d row_id1=%0d busy=%b expected 6 5 0111",
                     count[9:5], row_id[15:8], busy);
        end
    endtask

    task automatic test_stream_wrap();
        int xfers = 0;
        int cyc   = 0;
        int tgt;
        int l;
        bit v;
        logic [NUM_CH-1:0] s;
        drive(0, 0, '0, 1);
        tick();
        while (xfers < 300 && cyc < 6000) begin
            s = NUM_CH'($urandom) & exp_busy();
            step = s;
            tgt = m_target();
            l = $urandom_range(0, 9);
            if ($urandom_range(0, 15) == 0) l = 31;
            if (tgt >= 0 && m_busy[tgt] && l == 0) l = 1;
            v = ($urandom_range(0, 3) != 0);
            drive(v, l, s, 0);
            checks++;
            if (len_ready !== m_ready()) begin
                failures++;
                $display("FAIL stream_ready cyc%0d: got %b expected %b", cyc, len_ready, m_ready());
            end
            if (v && m_ready()) xfers++;
            tick();
            checks++;
            if (count !== exp_count() || busy !== exp_busy()) begin
                failures++;
                $display("FAIL stream_lanes cyc%0d: got count=%h busy=%b expected %h %b",
                         cyc, count, busy, exp_count(), exp_busy());
            end
            checks++;
            if (row_id !== exp_row_id() || row_done !== exp_done() || done_id !== exp_done_id()) begin
                failures++;
                $display("FAIL stream_ids cyc%0d: got id=%h done=%b did=%h expected %h %b %h",
                         cyc, row_id, row_done, done_id, exp_row_id(), exp_done(), exp_done_id());
            end
            checks++;
            if (err_step !== m_err) begin
                failures++;
                $display("FAIL stream_err cyc%0d: got %b expected %b", cyc, err_step, m_err);
            end
            cyc++;
        end
        checks++;
        if (xfers < 300) begin
            failures++;
            $display("FAIL stream_timeout: got %0d transfers expected 300", xfers);
        end
        drive(0, 0, '0, 1);
        tick();
        drive(0, 0, 4'b0100, 0);
        tick();
        checks++;
        if (err_step !== 1'b1 || busy !== 4'b0000) begin
            failures++;
            $display("FAIL err_set: got err=%b busy=%b expected 1 0000", err_step, busy);
        end
        repeat (3) begin
            drive(1, 2, '0, 0);
            tick();
        end
        checks++;
        if (err_step !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: got %b expected 1", err_step);
        end
    endtask

    task automatic test_flush_reset();
        drive(0, 0, 4'b0111, 0);
        tick();
        drive(1, 9, '0, 1);
        tick();
        checks++;
        if ({count, row_id, busy, row_done, done_id} !== '0 || err_step !== 1'b1) begin
            failures++;
            $display("FAIL flush_clear: got count=%h id=%h busy=%b done=%b did=%h err=%b expected zeros err=1",
                     count, row_id, busy, row_done, done_id, err_step);
        end
        drive(1, 3, '0, 0);
        tick();
        drive(1, 4, '0, 0);
        tick();
        checks++;
        if (row_id[7:0] !== 8'd0 || row_id[15:8] !== 8'd1 || busy !== 4'b0011) begin
            failures++;
            $display("FAIL flush_restart: got id0=%0d id1=%0d busy=%b expected 0 1 0011",
                     row_id[7:0], row_id[15:8], busy);
        end
        drive(0, 0, 4'b0011, 0);
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({count, row_id, busy, row_done, done_id, err_step} !== '0) begin
            failures++;
            $display("FAIL async_reset: got count=%h id=%h busy=%b err=%b expected zeros",
                     count, row_id, busy, err_step);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1, 2, '0, 0);
        tick();
        checks++;
        if (row_id[7:0] !== 8'd0 || busy !== 4'b0001 || count[4:0] !== 5'd2) begin
            failures++;
            $display("FAIL reset_restart: got id0=%0d busy=%b cnt0=%0d expected 0 0001 2",
                     row_id[7:0], busy, count[4:0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_back_to_back();
        test_zero_len();
        test_reload();
        test_stream_wrap();
        test_flush_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
